// File: rtl/timer_ctrl_pkg.sv
// Shared types for the event timer: controller state and counting mode.
package timer_ctrl_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    typedef enum logic {ONE_SHOT = 1'b0, PERIODIC = 1'b1} mode_e;
endpackage

// File: rtl/strobe_div.sv
// Free-running divider: one-cycle strobe every DIV clocks, counter held at 0 in reset.
module strobe_div #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_strobe
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Strobe on the last count so the first one lands DIV edges after reset release.
    always_comb begin
        o_strobe = (cnt_q == LAST);
        cnt_d    = o_strobe ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/timer_ctrl.sv
// Programmable one-shot/periodic event timer on top of a prescaled base tick,
// with a valid/ready event output and a sticky overrun flag.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int PRESCALE = 10,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CNT_W-1:0] i_cfg_period,
    input  logic             i_cfg_periodic,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_busy,
    output logic             o_event_valid,
    input  logic             i_event_ready,
    output logic             o_overrun,
    input  logic             i_clr_overrun
);
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("timer_ctrl: PRESCALE must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("timer_ctrl: CNT_W must be >= 1");
    end

    state_e           state_q, state_d;
    mode_e            periodic_q, periodic_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             event_valid_q, event_valid_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] eff_period;
    logic             presc_rst, tick, expiry;

    // Prescaler only runs in RUN, so tick phase is aligned to the start edge.
    assign presc_rst = (state_q != RUN);

    strobe_div #(.DIV(PRESCALE)) u_presc (
        .i_clk    (i_clk),
        .i_reset  (presc_rst),
        .o_strobe (tick)
    );

    assign expiry = (state_q == RUN) && tick && (remaining_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        periodic_d  = periodic_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        eff_period  = i_cfg_valid ? i_cfg_period : period_q;
        case (state_q)
            IDLE: begin
                if (i_cfg_valid) begin
                    period_d   = i_cfg_period;
                    periodic_d = mode_e'(i_cfg_periodic);
                end
                if (i_start && !i_stop && (eff_period != '0)) begin
                    state_d     = RUN;
                    remaining_d = eff_period;
                end
            end
            RUN: begin
                if (expiry) begin
                    if (periodic_q == PERIODIC) begin
                        remaining_d = period_q;
                    end else begin
                        state_d     = IDLE;
                        remaining_d = '0;
                    end
                end else if (tick) begin
                    remaining_d = remaining_q - CNT_W'(1);
                end
                // Stop discards the count but never suppresses a same-edge expiry.
                if (i_stop) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        event_valid_d = event_valid_q;
        overrun_d     = overrun_q;
        if (event_valid_q && i_event_ready) event_valid_d = 1'b0;
        if (expiry)                         event_valid_d = 1'b1;
        if (i_clr_overrun)                  overrun_d     = 1'b0;
        if (expiry && event_valid_q && !i_event_ready) overrun_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= IDLE;
            periodic_q    <= ONE_SHOT;
            period_q      <= '0;
            remaining_q   <= '0;
            event_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            periodic_q    <= periodic_d;
            period_q      <= period_d;
            remaining_q   <= remaining_d;
            event_valid_q <= event_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign o_busy        = (state_q == RUN);
    assign o_cfg_ready   = (state_q == IDLE);
    assign o_event_valid = event_valid_q;
    assign o_overrun     = overrun_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expiry-schedule model checked every cycle plus literal checkpoints.
module tb_timer_ctrl;
    localparam int P = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_period = '0;
    logic         cfg_periodic = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         busy;
    logic         ev_valid;
    logic         ev_ready = 1'b1;
    logic         overrun;
    logic         clr_ovr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_ctrl #(.PRESCALE(P), .CNT_W(W)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_cfg_valid    (cfg_valid),
        .o_cfg_ready    (cfg_ready),
        .i_cfg_period   (cfg_period),
        .i_cfg_periodic (cfg_periodic),
        .i_start        (start),
        .i_stop         (stop),
        .o_busy         (busy),
        .o_event_valid  (ev_valid),
        .i_event_ready  (ev_ready),
        .o_overrun      (overrun),
        .i_clr_overrun  (clr_ovr)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a run started at edge t0 expires at every edge t0 + k*period*P
    // (only k=1 for one-shot); event/overrun follow the handshake rules.
    int m_run = 0, m_n = 0, m_per = 0, m_mode = 0;
    int m_cfg_per = 0, m_cfg_mode = 0;
    int m_valid = 0, m_ovr = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_n = 0; m_per = 0; m_mode = 0;
            m_cfg_per = 0; m_cfg_mode = 0; m_valid = 0; m_ovr = 0;
        end else begin
            int exp_now;
            int eff;
            int nv;
            exp_now = 0;
            if (m_run != 0) begin
                m_n++;
                if ((m_n % (m_per * P)) == 0) exp_now = 1;
                if (exp_now != 0 && m_mode == 0) m_run = 0;
                if (stop) m_run = 0;
            end else begin
                if (cfg_valid) begin
                    m_cfg_per  = int'(cfg_period);
                    m_cfg_mode = int'(cfg_periodic);
                end
                eff = m_cfg_per;
                if (start && !stop && eff != 0) begin
                    m_run = 1; m_n = 0; m_per = eff; m_mode = m_cfg_mode;
                end
            end
            nv = m_valid;
            if (m_valid != 0 && ev_ready) nv = 0;
            if (exp_now != 0) nv = 1;
            if (clr_ovr) m_ovr = 0;
            if (exp_now != 0 && m_valid != 0 && !ev_ready) m_ovr = 1;
            m_valid = nv;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model busy",      int'(busy),      m_run);
            chk("model cfg_ready", int'(cfg_ready), (m_run == 0) ? 1 : 0);
            chk("model ev_valid",  int'(ev_valid),  m_valid);
            chk("model overrun",   int'(overrun),   m_ovr);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic config_(input int per, input logic periodic);
        cfg_valid = 1'b1; cfg_period = W'(per); cfg_periodic = periodic;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic start_(); // returns just after edge t0
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        step(2);
        chk("reset busy", int'(busy), 0);
        chk("reset ev_valid", int'(ev_valid), 0);
        chk("reset overrun", int'(overrun), 0);
        chk("reset cfg_ready", int'(cfg_ready), 1);
        rst = 1'b0;
        step(1);

        // 1: one-shot period 3
        config_(3, 1'b0);
        start_();
        chk("t1 busy t0", int'(busy), 1);
        chk("t1 cfg_ready t0", int'(cfg_ready), 0);
        step(11);
        chk("t1 valid t0+11", int'(ev_valid), 0);
        step(1);
        chk("t1 valid t0+12", int'(ev_valid), 1);
        chk("t1 busy t0+12", int'(busy), 0);
        step(1);
        chk("t1 valid t0+13", int'(ev_valid), 0);
        chk("t1 cfg_ready", int'(cfg_ready), 1);

        // 2: periodic period 2, stop at t0+18
        config_(2, 1'b1);
        start_();
        step(8);
        chk("t2 valid t0+8", int'(ev_valid), 1);
        step(1);
        chk("t2 valid t0+9", int'(ev_valid), 0);
        step(7);
        chk("t2 valid t0+16", int'(ev_valid), 1);
        step(1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t2 busy t0+18", int'(busy), 0);
        step(6);
        chk("t2 valid t0+24", int'(ev_valid), 0);

        // 3: periodic period 1 with consumer stalled
        ev_ready = 1'b0;
        config_(1, 1'b1);
        start_();
        step(4);
        chk("t3 valid t0+4", int'(ev_valid), 1);
        chk("t3 ovr t0+4", int'(overrun), 0);
        step(4);
        chk("t3 ovr t0+8", int'(overrun), 1);
        chk("t3 valid t0+8", int'(ev_valid), 1);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        chk("t3 ovr cleared", int'(overrun), 0);
        step(2);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        chk("t3 set beats clr", int'(overrun), 1);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        chk("t3 ovr cleared 2", int'(overrun), 0);
        ev_ready = 1'b1;
        step(1);
        chk("t3 valid drained", int'(ev_valid), 0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t3 stopped", int'(busy), 0);

        // 4: zero period ignored, then config+start in one cycle
        config_(0, 1'b0);
        start_();
        chk("t4 zero busy", int'(busy), 0);
        step(50);
        chk("t4 zero no event", int'(ev_valid), 0);
        cfg_valid = 1'b1; cfg_period = W'(5); cfg_periodic = 1'b0; start = 1'b1;
        step(1);
        cfg_valid = 1'b0; start = 1'b0;
        chk("t4 cfg+start busy", int'(busy), 1);
        step(19);
        chk("t4 valid t0+19", int'(ev_valid), 0);
        step(1);
        chk("t4 valid t0+20", int'(ev_valid), 1);
        chk("t4 busy t0+20", int'(busy), 0);
        step(1);

        // 5: start+stop together, then config attempt while running
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("t5 start+stop", int'(busy), 0);
        start_();
        chk("t5 cfg_ready run", int'(cfg_ready), 0);
        cfg_valid = 1'b1; cfg_period = W'(9); cfg_periodic = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        step(19);
        chk("t5 old period expiry", int'(ev_valid), 1);
        chk("t5 still one-shot", int'(busy), 0);
        step(1);

        // 6: async reset mid-run, then start with no config
        ev_ready = 1'b0;
        config_(1, 1'b1);
        start_();
        step(8);
        chk("t6 pre-rst ovr", int'(overrun), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6 rst busy", int'(busy), 0);
        chk("t6 rst valid", int'(ev_valid), 0);
        chk("t6 rst ovr", int'(overrun), 0);
        chk("t6 rst cfg_ready", int'(cfg_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        ev_ready = 1'b1;
        start_();
        chk("t6 start no cfg", int'(busy), 0);
        step(20);
        chk("t6 no event", int'(ev_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
